// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute unit: opcodes, FSM encoding, flag bit positions.
// Flags are packed as {Z,N,C,V}; use pack_flags so the indices stay in one place.
package alu_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_MUL = 3'b000;
  localparam logic [OPW-1:0] OP_ADD = 3'b001;
  localparam logic [OPW-1:0] OP_SUB = 3'b010;
  localparam logic [OPW-1:0] OP_AND = 3'b011;
  localparam logic [OPW-1:0] OP_OR  = 3'b100;
  localparam logic [OPW-1:0] OP_NOT = 3'b101;
  localparam logic [OPW-1:0] OP_INC = 3'b110;
  localparam logic [OPW-1:0] OP_DEC = 3'b111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, W cycles after start.
// done_o is high in the last step; prod_o carries the full 2W-bit product in that cycle.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           done_o,
  output logic [2*W-1:0] prod_o
);

  localparam int CW = $clog2(W);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] acc_step;

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o   = run_q && (cnt_q == CW'(W-1));
  // Final bit is folded in combinationally so the product is ready on the done step.
  assign prod_o   = acc_step;

  always_comb begin
    cnt_d    = cnt_q;
    run_d    = run_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start_i) begin
      cnt_d    = '0;
      run_d    = 1'b1;
      acc_d    = '0;
      mcand_d  = {{W{1'b0}}, a_i};
      mplier_d = b_i;
    end else if (run_q) begin
      acc_d    = acc_step;
      mcand_d  = {mcand_q[2*W-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[W-1:1]};
      if (done_o) begin
        cnt_d = '0;
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      run_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit: accept in IDLE, one EXEC cycle (W for MUL), hold result in DONE.
// Result is valid 2 cycles after accept (W+1 for MUL) and held until out_ready; no new accept meanwhile.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int W  = 8,
  parameter int IW = OPW + 2*W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  result,
  output logic [3:0]    flags,
  output logic          busy
);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   result_q, result_d;
  logic [3:0]     flags_q, flags_d;

  logic           accept;
  logic           mul_start;
  logic           mul_done;
  logic [2*W-1:0] mul_prod;

  logic [W-1:0]   opb;
  logic [W:0]     sum_w;
  logic [W:0]     diff_w;
  logic [W-1:0]   alu_res;
  logic           alu_c;
  logic           alu_v;
  logic [3:0]     alu_flags;

  // in_ready is gated by rst so nothing is accepted during a reset cycle.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (instr[IW-1:2*W] == OP_MUL);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;
  assign flags     = flags_q;

  alu_mul_seq #(.W(W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .a_i     (instr[2*W-1:W]),
    .b_i     (instr[W-1:0]),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  always_comb begin
    opb     = b_q;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    if (op_q == OP_INC || op_q == OP_DEC) begin
      opb = {{(W-1){1'b0}}, 1'b1};
    end
    sum_w  = {1'b0, a_q} + {1'b0, opb};
    diff_w = {1'b0, a_q} - {1'b0, opb};
    case (op_q)
      OP_MUL: begin
        alu_res = mul_prod[W-1:0];
        alu_c   = |mul_prod[2*W-1:W];
      end
      OP_ADD, OP_INC: begin
        alu_res = sum_w[W-1:0];
        alu_c   = sum_w[W];
        alu_v   = (a_q[W-1] == opb[W-1]) && (alu_res[W-1] != a_q[W-1]);
      end
      OP_SUB, OP_DEC: begin
        alu_res = diff_w[W-1:0];
        alu_c   = diff_w[W];
        alu_v   = (a_q[W-1] != opb[W-1]) && (alu_res[W-1] != a_q[W-1]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_NOT:  alu_res = ~a_q;
      default: alu_res = '0;
    endcase
    alu_flags = pack_flags(alu_res == '0, alu_res[W-1], alu_c, alu_v);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = instr[IW-1:2*W];
          a_d     = instr[2*W-1:W];
          b_d     = instr[W-1:0];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_q != OP_MUL || mul_done) begin
          result_d = alu_res;
          flags_d  = alu_flags;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit at W=8; expected values are hand-computed constants.
module tb_alu_exec_unit;

  localparam logic [2:0] MUL = 3'b000;
  localparam logic [2:0] ADD = 3'b001;
  localparam logic [2:0] SUB = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] OR  = 3'b100;
  localparam logic [2:0] NOT = 3'b101;
  localparam logic [2:0] INC = 3'b110;
  localparam logic [2:0] DEC = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  result;
  logic [3:0]  flags;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_unit #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Drives one instruction with out_ready held high and reports what it observed.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic [3:0] fl, output int lat,
                        output logic ov_after, output logic busy_ok);
    in_valid  = 1'b1;
    instr     = {op, a, b};
    out_ready = 1'b1;
    lat       = 0;
    busy_ok   = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end while (out_valid !== 1'b1 && lat < 40);
    if (out_valid !== 1'b1) lat = -1;
    res = result;
    fl  = flags;
    @(negedge clk);
    ov_after  = out_valid;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, busy, result, flags} !== {1'b0, 1'b0, 1'b0, 8'h00, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_state: rdy/ov/busy/res/flags got %b %b %b %h %b want 0 0 0 00 0000",
               in_ready, out_valid, busy, result, flags);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: in_ready/busy got %b%b want 10", in_ready, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [7:0] r; logic [3:0] f; int lat; logic ova, bok;
    run_op(ADD, 8'h23, 8'h14, r, f, lat, ova, bok);
    n_checks++;
    if ({r, f} !== {8'h37, 4'b0000}) begin
      n_fail++; $display("FAIL add_basic: got %h/%b want 37/0000", r, f);
    end
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL add_latency: got %0d want 2", lat);
    end
    n_checks++;
    if (ova !== 1'b0) begin
      n_fail++; $display("FAIL add_one_cycle_valid: out_valid after handshake got %b want 0", ova);
    end
  endtask

  task automatic test_sub();
    logic [7:0] r; logic [3:0] f; int lat; logic ova, bok;
    run_op(SUB, 8'h23, 8'h14, r, f, lat, ova, bok);
    n_checks++;
    if ({r, f, lat} !== {8'h0F, 4'b0000, 32'sd2}) begin
      n_fail++; $display("FAIL sub_pos: got %h/%b lat %0d want 0f/0000 lat 2", r, f, lat);
    end
    run_op(SUB, 8'h14, 8'h23, r, f, lat, ova, bok);
    n_checks++;
    if ({r, f} !== {8'hF1, 4'b0110}) begin
      n_fail++; $display("FAIL sub_borrow: got %h/%b want f1/0110", r, f);
    end
    run_op(SUB, 8'h80, 8'h01, r, f, lat, ova, bok);
    n_checks++;
    if ({r, f} !== {8'h7F, 4'b0001}) begin
      n_fail++; $display("FAIL sub_overflow: got %h/%b want 7f/0001", r, f);
    end
  endtask

  task automatic test_logic();
    logic [7:0] r; logic [3:0] f; int lat; logic ova, bok;
    run_op(AND, 8'hF0, 8'h3C, r, f, lat, ova, bok);
    n_checks++;
    if ({r, f} !== {8'h30, 4'b0000}) begin
      n_fail++; $display("FAIL and: got %h/%b want 30/0000", r, f);
    end
    run_op(OR, 8'h0F, 8'h80, r, f, lat, ova, bok);
    n_checks++;
    if ({r, f} !== {8'h8F, 4'b0100}) begin
      n_fail++; $display("FAIL or: got %h/%b want 8f/0100", r, f);
    end
    run_op(NOT, 8'hFF, 8'h55, r, f, lat, ova, bok);
    n_checks++;
    if ({r, f, lat} !== {8'h00, 4'b1000, 32'sd2}) begin
      n_fail++; $display("FAIL not: got %h/%b lat %0d want 00/1000 lat 2", r, f, lat);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] r; logic [3:0] f; int lat; logic ova, bok;
    run_op(ADD, 8'hFF, 8'h01, r, f, lat, ova, bok);
    n_checks++;
    if ({r, f} !== {8'h00, 4'b1010}) begin
      n_fail++; $display("FAIL add_wrap: got %h/%b want 00/1010", r, f);
    end
    run_op(INC, 8'h7F, 8'hAA, r, f, lat, ova, bok);
    n_checks++;
    if ({r, f, lat} !== {8'h80, 4'b0101, 32'sd2}) begin
      n_fail++; $display("FAIL inc_overflow: got %h/%b lat %0d want 80/0101 lat 2", r, f, lat);
    end
    run_op(DEC, 8'h00, 8'h33, r, f, lat, ova, bok);
    n_checks++;
    if ({r, f} !== {8'hFF, 4'b0110}) begin
      n_fail++; $display("FAIL dec_zero: got %h/%b want ff/0110", r, f);
    end
    run_op(ADD, 8'h7F, 8'h01, r, f, lat, ova, bok);
    n_checks++;
    if ({r, f} !== {8'h80, 4'b0101}) begin
      n_fail++; $display("FAIL add_overflow: got %h/%b want 80/0101", r, f);
    end
  endtask

  task automatic test_mul();
    logic [7:0] r; logic [3:0] f; int lat; logic ova, bok;
    run_op(MUL, 8'h23, 8'h14, r, f, lat, ova, bok);
    n_checks++;
    if ({r, f} !== {8'hBC, 4'b0110}) begin
      n_fail++; $display("FAIL mul_basic: got %h/%b want bc/0110", r, f);
    end
    n_checks++;
    if (lat !== 9) begin
      n_fail++; $display("FAIL mul_latency: got %0d want 9", lat);
    end
    n_checks++;
    if ({bok, ova} !== 2'b10) begin
      n_fail++; $display("FAIL mul_busy_valid: busy_held/ov_after got %b%b want 10", bok, ova);
    end
    run_op(MUL, 8'h0F, 8'h0F, r, f, lat, ova, bok);
    n_checks++;
    if ({r, f} !== {8'hE1, 4'b0100}) begin
      n_fail++; $display("FAIL mul_no_carry: got %h/%b want e1/0100", r, f);
    end
    run_op(MUL, 8'h00, 8'h55, r, f, lat, ova, bok);
    n_checks++;
    if ({r, f, lat} !== {8'h00, 4'b1000, 32'sd9}) begin
      n_fail++; $display("FAIL mul_zero: got %h/%b lat %0d want 00/1000 lat 9", r, f, lat);
    end
    run_op(MUL, 8'hFF, 8'hFF, r, f, lat, ova, bok);
    n_checks++;
    if ({r, f} !== {8'h01, 4'b0010}) begin
      n_fail++; $display("FAIL mul_max: got %h/%b want 01/0010", r, f);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r; logic [3:0] f; int lat; logic ova, bok;
    logic [7:0] exp_r [4] = '{8'h02, 8'h04, 8'h06, 8'h08};
    for (int i = 0; i < 4; i++) begin
      logic [7:0] av;
      av = 8'(i + 1);
      run_op(ADD, av, av, r, f, lat, ova, bok);
      n_checks++;
      if ({r, f, lat} !== {exp_r[i], 4'b0000, 32'sd2}) begin
        n_fail++; $display("FAIL b2b_add[%0d]: got %h/%b lat %0d want %h/0000 lat 2", i, r, f, lat, exp_r[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int  lat;
    logic extra;
    in_valid  = 1'b1;
    instr     = {ADD, 8'h10, 8'h05};
    out_ready = 1'b0;
    lat       = 0;
    do begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
    end while (out_valid !== 1'b1 && lat < 40);
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL bp_latency: got %0d want 2", lat);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid, in_ready, result, flags} !== {1'b1, 1'b0, 8'h15, 4'b0000}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: ov/rdy/res/flags got %b %b %h %b want 1 0 15 0000",
                 i, out_valid, in_ready, result, flags);
      end
      in_valid = (i == 1);
      instr    = (i == 1) ? {SUB, 8'h99, 8'h11} : {ADD, 8'h10, 8'h05};
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_fail++; $display("FAIL bp_release: ov/busy/rdy got %b%b%b want 001", out_valid, busy, in_ready);
    end
    extra = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) extra = 1'b1;
    end
    n_checks++;
    if (extra !== 1'b0) begin
      n_fail++; $display("FAIL bp_ignored_instr: unit activity got %b want 0", extra);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] r; logic [3:0] f; int lat; logic ova, bok;
    logic seen;
    in_valid  = 1'b1;
    instr     = {MUL, 8'h23, 8'h14};
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, out_valid, in_ready, result, flags} !== {1'b0, 1'b0, 1'b0, 8'h00, 4'h0}) begin
      n_fail++;
      $display("FAIL rst_mid_mul: busy/ov/rdy/res/flags got %b %b %b %h %b want 0 0 0 00 0000",
               busy, out_valid, in_ready, result, flags);
    end
    rst  = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_mul_pulse: out_valid seen got %b want 0", seen);
    end
    run_op(ADD, 8'h23, 8'h14, r, f, lat, ova, bok);
    n_checks++;
    if ({r, f, lat} !== {8'h37, 4'b0000, 32'sd2}) begin
      n_fail++; $display("FAIL rst_then_add: got %h/%b lat %0d want 37/0000 lat 2", r, f, lat);
    end

    in_valid  = 1'b1;
    instr     = {ADD, 8'h01, 8'h01};
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, result} !== {1'b1, 8'h02}) begin
      n_fail++; $display("FAIL rst_done_pre: ov/res got %b %h want 1 02", out_valid, result);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({out_valid, busy, result, flags} !== {1'b0, 1'b0, 8'h00, 4'h0}) begin
      n_fail++; $display("FAIL rst_in_done: ov/busy/res/flags got %b %b %h %b want 0 0 00 0000",
                         out_valid, busy, result, flags);
    end
    out_ready = 1'b1;
    seen      = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    out_ready = 1'b0;
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL rst_in_done_pulse: out_valid seen got %b want 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_boundaries();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: W, default 8, operand/result width in bits (W >= 4).
REQ-002 Parameter: OPW, fixed 3, opcode width; instruction width IW = OPW + 2*W (19 at W=8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  instruction presented.
REQ-006 in_ready  output  1  unit accepts instruction this cycle.
REQ-007 instr  input  IW  [IW-1:2W] opcode, [2W-1:W] operand A, [W-1:0] operand B.
REQ-008 out_valid  output  1  result/flags valid.
REQ-009 out_ready  input  1  consumer takes result this cycle.
REQ-010 result  output  W  operation result.
REQ-011 flags  output  4  {Z,N,C,V}: zero, negative (MSB), carry/borrow, signed overflow.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Opcodes SHALL be: 000 MUL, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 NOT A (B ignored), 110 INC A, 111 DEC A.
REQ-014 FSM states SHALL be IDLE, EXEC, DONE.
REQ-015 in_ready SHALL equal (state==IDLE); accept on in_valid && in_ready at a rising edge; opcode/A/B captured into registers, IDLE->EXEC.
REQ-016 Opcodes 001-111 SHALL spend exactly one cycle in EXEC; result/flags registered at that edge, EXEC->DONE; out_valid high on the second cycle after accept.
REQ-017 MUL SHALL be iterative shift-add, one multiplier bit per cycle, W cycles in EXEC; out_valid high W+1 cycles after accept.
REQ-018 MUL result SHALL be low W bits of the 2W-bit product; C=1 iff high W bits nonzero; V=0.
REQ-019 ADD/INC: C = carry out of bit W-1; V = signed overflow.
REQ-020 SUB/DEC: C = borrow (A<B unsigned, or A==0 for DEC); V = signed overflow.
REQ-021 AND/OR/NOT: C=0, V=0.
REQ-022 Z = (result==0); N = result[W-1], for all opcodes.
REQ-023 In DONE, result/flags/out_valid SHALL hold stable until out_valid && out_ready; then out_valid deasserts next cycle, DONE->IDLE.
REQ-024 No instruction accepted in EXEC or DONE; in_valid there is ignored and instr not sampled.
REQ-025 Arithmetic SHALL wrap modulo 2^W; no saturation.

Reset
REQ-026 rst high at an edge SHALL force state=IDLE, out_valid=0, result=0, flags=0, MUL counter/partial product=0, regardless of current state.
REQ-027 Reset mid-MUL or in DONE SHALL discard the operation without any out_valid pulse.
REQ-028 in_ready SHALL be 0 while rst is high and 1 on the first cycle after rst deasserts.

Structure
REQ-029 Shared package alu_pkg SHALL hold opcode localparams, FSM state encoding and flag bit indices (Z=3,N=2,C=1,V=0).
REQ-030 Iterative multiplier SHALL be one sub-module alu_mul_seq (start, done, W-parameterised, counter and partial product internal).
REQ-031 Single-cycle ops SHALL be combinational logic inside alu_exec_unit feeding the output registers.

Verification (W=8)
REQ-032 ADD A=0x23 B=0x14, out_ready=1 -> result 0x37, flags 0000, out_valid 2 cycles after accept, one cycle wide.
REQ-033 SUB 0x23-0x14 -> 0x0F flags 0000; SUB 0x14-0x23 -> 0xF1, N=1 C=1.
REQ-034 MUL 0x23*0x14 -> result 0xBC, C=1, out_valid exactly 9 cycles after accept; busy high throughout.
REQ-035 Boundaries: ADD 0xFF+0x01 -> 0x00 Z=1 C=1; INC 0x7F -> 0x80 N=1 V=1; DEC 0x00 -> 0xFF N=1 C=1.
REQ-036 Backpressure: out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0, second in_valid ignored; release -> single handshake then IDLE.
REQ-037 rst asserted 4 cycles into MUL -> next cycle IDLE, out_valid=0, result=0; following ADD executes correctly.
